adder_accumulator: RTL and testbench

- Sequential accumulate stage wrapped around the N-bit ripple adder.
- Drives the adder's A and B operand inputs, with A taken from the incoming operand and B from the running total.
- Captures the adder's Sum and Cout on every accepted operand.
- Sums a programmed count of operands from a valid/ready stream, then holds the total with a sticky carry flag, a carry counter and a zero flag until restarted.

---
 rtl/adder_accumulator_if.sv | 11 +
 rtl/adder_accumulator.sv | 124 ++++++++++++
 tb/tb_adder_accumulator.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/adder_accumulator_if.sv
// Operand stream bundle: valid/ready handshake carrying one N-bit operand per transfer.
interface adder_accumulator_if #(
  parameter int N = 4
);
  logic         op_valid;
  logic [N-1:0] op_data;
  logic         op_ready;

  modport master (output op_valid, output op_data, input op_ready);
  modport slave  (input op_valid, input op_data, output op_ready);
endinterface

// File: rtl/adder_accumulator.sv
// Accumulate stage around an external N-bit adder: sums num_ops streamed operands
// and holds the total with sticky carry, carry count and zero flags until restarted.
module adder_accumulator #(
  parameter int N  = 4,
  parameter int CW = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [CW-1:0]        num_ops,
  adder_accumulator_if.slave   op,
  output logic [N-1:0]         add_a,
  output logic [N-1:0]         add_b,
  input  logic [N-1:0]         add_sum,
  input  logic                 add_cout,
  output logic [N-1:0]         acc,
  output logic                 flagC,
  output logic [CW-1:0]        carry_cnt,
  output logic                 flagZ,
  output logic                 busy,
  output logic                 done
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ACCUM = 2'b01,
    ST_DONE  = 2'b10
  } state_t;

  state_t        state_r, state_nxt_s;
  logic [N-1:0]  acc_r, acc_nxt_s;
  logic          flag_c_r, flag_c_nxt_s;
  logic [CW-1:0] cnt_r, cnt_nxt_s;
  logic          flag_z_r, flag_z_nxt_s;
  logic [CW-1:0] rem_r, rem_nxt_s;
  logic          xfer_s;

  // The adder loop stays purely combinational: operand straight in, total fed back.
  assign add_a = op.op_data;
  assign add_b = acc_r;

  assign xfer_s = op.op_valid && (state_r == ST_ACCUM);

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= ST_IDLE;
      acc_r    <= {N{1'b0}};
      flag_c_r <= 1'b0;
      cnt_r    <= {CW{1'b0}};
      flag_z_r <= 1'b0;
      rem_r    <= {CW{1'b0}};
    end else begin
      state_r  <= state_nxt_s;
      acc_r    <= acc_nxt_s;
      flag_c_r <= flag_c_nxt_s;
      cnt_r    <= cnt_nxt_s;
      flag_z_r <= flag_z_nxt_s;
      rem_r    <= rem_nxt_s;
    end
  end

  // Next-state and next-datapath decode; DONE restarts exactly like IDLE.
  always_comb begin
    state_nxt_s  = state_r;
    acc_nxt_s    = acc_r;
    flag_c_nxt_s = flag_c_r;
    cnt_nxt_s    = cnt_r;
    flag_z_nxt_s = flag_z_r;
    rem_nxt_s    = rem_r;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          acc_nxt_s    = {N{1'b0}};
          flag_c_nxt_s = 1'b0;
          cnt_nxt_s    = {CW{1'b0}};
          rem_nxt_s    = num_ops;
          if (num_ops == {CW{1'b0}}) begin
            state_nxt_s  = ST_DONE;
            flag_z_nxt_s = 1'b1;
          end else begin
            state_nxt_s  = ST_ACCUM;
            flag_z_nxt_s = 1'b0;
          end
        end else begin
          state_nxt_s = state_r;
        end
      end
      ST_ACCUM: begin
        if (xfer_s) begin
          acc_nxt_s    = add_sum;
          flag_c_nxt_s = flag_c_r | add_cout;
          rem_nxt_s    = rem_r - {{(CW-1){1'b0}}, 1'b1};
          // Saturating carry counter: sticks at all-ones.
          if (cnt_r != {CW{1'b1}}) begin
            cnt_nxt_s = cnt_r + {{(CW-1){1'b0}}, add_cout};
          end else begin
            cnt_nxt_s = cnt_r;
          end
          if (rem_r == {{(CW-1){1'b0}}, 1'b1}) begin
            state_nxt_s  = ST_DONE;
            flag_z_nxt_s = (add_sum == {N{1'b0}});
          end else begin
            state_nxt_s = ST_ACCUM;
          end
        end else begin
          state_nxt_s = ST_ACCUM;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  assign op.op_ready = (state_r == ST_ACCUM);
  assign busy        = (state_r == ST_ACCUM);
  assign done        = (state_r == ST_DONE);
  assign acc         = acc_r;
  assign flagC       = flag_c_r;
  assign carry_cnt   = cnt_r;
  assign flagZ       = flag_z_r;

endmodule

// File: tb/tb_adder_accumulator.sv
// Directed bench for adder_accumulator: cycle-by-cycle vector table plus reset-mid-run sequence.
module tb_adder_accumulator;

  localparam int N  = 4;
  localparam int CW = 4;

  logic          clk;
  logic          rst;
  logic          start;
  logic [CW-1:0] num_ops;
  logic [N-1:0]  add_a, add_b, add_sum, acc;
  logic          add_cout, flagC, flagZ, busy, done;
  logic [CW-1:0] carry_cnt;

  adder_accumulator_if #(.N(N)) op_if ();

  adder_accumulator #(.N(N), .CW(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .num_ops   (num_ops),
    .op        (op_if.slave),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_sum   (add_sum),
    .add_cout  (add_cout),
    .acc       (acc),
    .flagC     (flagC),
    .carry_cnt (carry_cnt),
    .flagZ     (flagZ),
    .busy      (busy),
    .done      (done)
  );

  // External ripple adder behaviour.
  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic       rst;
    logic       start;
    logic [3:0] num;
    logic       valid;
    logic [3:0] data;
    logic [3:0] e_acc;
    logic       e_c;
    logic [3:0] e_cnt;
    logic       e_z;
    logic       e_busy;
    logic       e_done;
  } vec_t;

  localparam int NV = 21;
  vec_t vecs [NV];

  function automatic vec_t mk(logic r, logic s, logic [3:0] n, logic v, logic [3:0] d,
                              logic [3:0] ea, logic ec, logic [3:0] en, logic ez,
                              logic eb, logic ed);
    vec_t t;
    t.rst = r; t.start = s; t.num = n; t.valid = v; t.data = d;
    t.e_acc = ea; t.e_c = ec; t.e_cnt = en; t.e_z = ez; t.e_busy = eb; t.e_done = ed;
    return t;
  endfunction

  task automatic check(input string name, input int row, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s (row %0d): got %0h, want %0h", name, row, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic s, input logic [3:0] n,
                       input logic v, input logic [3:0] d);
    rst = r; start = s; num_ops = n; op_if.op_valid = v; op_if.op_data = d;
  endtask

  task automatic check_all(input int row, input logic [3:0] ea, input logic ec,
                           input logic [3:0] en, input logic ez, input logic eb,
                           input logic ed, input logic [3:0] d);
    check("acc", row, 32'(acc), 32'(ea));
    check("flagC", row, 32'(flagC), 32'(ec));
    check("carry_cnt", row, 32'(carry_cnt), 32'(en));
    check("flagZ", row, 32'(flagZ), 32'(ez));
    check("busy", row, 32'(busy), 32'(eb));
    check("done", row, 32'(done), 32'(ed));
    check("op_ready", row, 32'(op_if.op_ready), 32'(eb));
    check("add_a", row, 32'(add_a), 32'(d));
    check("add_b", row, 32'(add_b), 32'(ea));
  endtask

  initial begin
    // rst start num valid data | acc C cnt Z busy done
    vecs[0]  = mk(1'b1, 1'b0, 4'd0, 1'b0, 4'd0,  4'd0,  1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    // basic carry run: 3, 5, 9 (start wins over op_valid)
    vecs[1]  = mk(1'b0, 1'b1, 4'd3, 1'b1, 4'd3,  4'd0,  1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
    vecs[2]  = mk(1'b0, 1'b0, 4'd0, 1'b1, 4'd3,  4'd3,  1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
    vecs[3]  = mk(1'b0, 1'b0, 4'd0, 1'b1, 4'd5,  4'd8,  1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
    vecs[4]  = mk(1'b0, 1'b0, 4'd0, 1'b1, 4'd9,  4'd1,  1'b1, 4'd1, 1'b0, 1'b0, 1'b1);
    vecs[5]  = mk(1'b0, 1'b0, 4'd0, 1'b1, 4'd7,  4'd1,  1'b1, 4'd1, 1'b0, 1'b0, 1'b1);
    // restart from DONE; start during ACCUM ignored
    vecs[6]  = mk(1'b0, 1'b1, 4'd1, 1'b1, 4'd6,  4'd0,  1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
    vecs[7]  = mk(1'b0, 1'b1, 4'd5, 1'b1, 4'd6,  4'd6,  1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
    // zero-result run: 8 + 8
    vecs[8]  = mk(1'b0, 1'b1, 4'd2, 1'b0, 4'd0,  4'd0,  1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
    vecs[9]  = mk(1'b0, 1'b0, 4'd0, 1'b1, 4'd8,  4'd8,  1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
    vecs[10] = mk(1'b0, 1'b0, 4'd0, 1'b1, 4'd8,  4'd0,  1'b1, 4'd1, 1'b1, 1'b0, 1'b1);
    // stall run: four 15s, valid 1,0,0,1,1,0,1
    vecs[11] = mk(1'b0, 1'b1, 4'd4, 1'b0, 4'd15, 4'd0,  1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
    vecs[12] = mk(1'b0, 1'b0, 4'd0, 1'b1, 4'd15, 4'd15, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
    vecs[13] = mk(1'b0, 1'b1, 4'd2, 1'b0, 4'd15, 4'd15, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
    vecs[14] = mk(1'b0, 1'b0, 4'd0, 1'b0, 4'd15, 4'd15, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
    vecs[15] = mk(1'b0, 1'b0, 4'd0, 1'b1, 4'd15, 4'd14, 1'b1, 4'd1, 1'b0, 1'b1, 1'b0);
    vecs[16] = mk(1'b0, 1'b0, 4'd0, 1'b1, 4'd15, 4'd13, 1'b1, 4'd2, 1'b0, 1'b1, 1'b0);
    vecs[17] = mk(1'b0, 1'b0, 4'd0, 1'b0, 4'd15, 4'd13, 1'b1, 4'd2, 1'b0, 1'b1, 1'b0);
    vecs[18] = mk(1'b0, 1'b0, 4'd0, 1'b1, 4'd15, 4'd12, 1'b1, 4'd3, 1'b0, 1'b0, 1'b1);
    // num_ops = 0: straight to DONE, operand never taken
    vecs[19] = mk(1'b0, 1'b1, 4'd0, 1'b1, 4'd5,  4'd0,  1'b0, 4'd0, 1'b1, 1'b0, 1'b1);
    vecs[20] = mk(1'b0, 1'b0, 4'd0, 1'b1, 4'd5,  4'd0,  1'b0, 4'd0, 1'b1, 1'b0, 1'b1);

    drive(1'b1, 1'b0, 4'd0, 1'b0, 4'd0);
    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].rst, vecs[i].start, vecs[i].num, vecs[i].valid, vecs[i].data);
      @(posedge clk);
      #1;
      check_all(i, vecs[i].e_acc, vecs[i].e_c, vecs[i].e_cnt, vecs[i].e_z,
                vecs[i].e_busy, vecs[i].e_done, vecs[i].data);
    end

    // Reset mid-run: 4-operand run interrupted after 1 + 2 = 3.
    drive(1'b0, 1'b1, 4'd4, 1'b0, 4'd1);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 4'd0, 1'b1, 4'd1);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 4'd0, 1'b1, 4'd2);
    @(posedge clk); #1;
    check_all(100, 4'd3, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 4'd2);
    drive(1'b1, 1'b0, 4'd0, 1'b1, 4'd15);
    @(posedge clk); #1;
    check_all(101, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd15);
    @(posedge clk); #1;
    check_all(102, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd15);
    drive(1'b0, 1'b0, 4'd0, 1'b1, 4'd15);
    @(posedge clk); #1;
    check_all(103, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd15);
    drive(1'b0, 1'b1, 4'd1, 1'b0, 4'd4);
    @(posedge clk); #1;
    check_all(104, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 4'd4);
    drive(1'b0, 1'b0, 4'd0, 1'b1, 4'd4);
    @(posedge clk); #1;
    check_all(105, 4'd4, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 4'd4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
